mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle joining the fetch and data requesters, the arbiter and the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshakes: a requester holds x_req and its fields stable until x_gnt is 1 in the same cycle.
  // x_valid is a one-cycle result pulse. mem_req holds the latched fields until mem_ready is 1.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_if;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_valid;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_gnt, if_valid, if_rdata, stall_if, d_gnt, d_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_gnt, if_valid, if_rdata, stall_if, d_gnt, d_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one memory port, one transaction at a time,
// with data priority bounded by a fetch starvation counter.
module mem_port_arbiter #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int MAX_WAIT = 4,
  localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] starve_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  state_t state;
  state_t state_nxt;

  logic grant_if;
  logic grant_d;
  logic done_if;
  logic done_d;

  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_be_q;
  logic                if_valid_q;
  logic                d_valid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  // Data wins a tie unless fetch has already been passed over MAX_WAIT times.
  assign grant_d  = (state == IDLE) && bus.d_req && !(bus.if_req && (starve_cnt >= CNT_MAX));
  assign grant_if = (state == IDLE) && bus.if_req && !grant_d;
  assign done_if  = (state == BUSY_IF) && bus.mem_ready;
  assign done_d   = (state == BUSY_D) && bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)       state_nxt = BUSY_D;
        else if (grant_if) state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.if_gnt    = grant_if;
    bus.d_gnt     = grant_d;
    bus.stall_if  = bus.if_req && !grant_if;
    bus.mem_req   = (state == BUSY_IF) || (state == BUSY_D);
    bus.mem_we    = mem_we_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.mem_be    = mem_be_q;
    bus.if_valid  = if_valid_q;
    bus.if_rdata  = if_rdata_q;
    bus.d_valid   = d_valid_q;
    bus.d_rdata   = d_rdata_q;
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && bus.if_req && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Transaction fields are captured only at grant, so they stay frozen for the whole busy phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant_d) begin
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        mem_be_q    <= bus.d_be;
      end else if (grant_if) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '0;
      end
      if_valid_q <= done_if;
      d_valid_q  <= done_d;
      if (done_if)              if_rdata_q <= bus.mem_rdata;
      if (done_d && !mem_we_q)  d_rdata_q  <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  logic             clk;
  logic             reset;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] starve_cnt;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fsm_state  (fsm_state),
    .starve_cnt (starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_arr [16];
  logic [DATA_W-1:0] mem_arr [16];

  bit                m_busy, m_is_d, m_we, m_ifv, m_dv, m_d_load, f_pend, d_pend;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_be;
  int                m_cnt;
  logic [DATA_W-1:0] exp_if_rdata, exp_d_rdata, d_next;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},    fsm_state, 2'd0);
    check({tag, "_starve"},   starve_cnt, 0);
    check({tag, "_mem_req"},  bus.mem_req, 1'b0);
    check({tag, "_mem_we"},   bus.mem_we, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wd"},   bus.mem_wdata, 0);
    check({tag, "_mem_be"},   bus.mem_be, 0);
    check({tag, "_if_valid"}, bus.if_valid, 1'b0);
    check({tag, "_d_valid"},  bus.d_valid, 1'b0);
    check({tag, "_if_rdata"}, bus.if_rdata, 0);
    check({tag, "_d_rdata"},  bus.d_rdata, 0);
  endtask

  task automatic drive_random();
    logic [3:0] idx;
    if (!f_pend) begin
      if ($urandom_range(2) == 0) begin
        f_pend      = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
      end else begin
        bus.if_req = 1'b0;
      end
    end else if ($urandom_range(24) == 0) begin
      f_pend     = 1'b0;
      bus.if_req = 1'b0;
    end
    if (!d_pend) begin
      if ($urandom_range(2) == 0) begin
        d_pend      = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(1));
        bus.d_addr  = {26'd0, 4'($urandom_range(15)), 2'b00};
        bus.d_wdata = $urandom;
        bus.d_be    = 4'($urandom_range(15));
      end else begin
        bus.d_req = 1'b0;
      end
    end else if ($urandom_range(24) == 0) begin
      d_pend    = 1'b0;
      bus.d_req = 1'b0;
    end
    // memory responder; mem_ready outside a transaction is noise the arbiter must ignore
    if (bus.mem_req && $urandom_range(2) == 0) begin
      bus.mem_ready = 1'b1;
      idx = bus.mem_addr[5:2];
      bus.mem_rdata = mem_arr[idx];
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem_arr[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end else begin
      bus.mem_ready = bus.mem_req ? 1'b0 : 1'($urandom_range(1));
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic model_step();
    bit         e_d, e_i;
    logic [3:0] idx;
    e_d = !m_busy && bus.d_req && !(bus.if_req && m_cnt >= MAX_WAIT);
    e_i = !m_busy && bus.if_req && !e_d;
    check("r_if_gnt",  bus.if_gnt, e_i);
    check("r_d_gnt",   bus.d_gnt, e_d);
    check("r_stall",   bus.stall_if, bus.if_req && !e_i);
    check("r_mem_req", bus.mem_req, m_busy);
    check("r_starve",  starve_cnt, m_cnt);
    check("r_if_vld",  bus.if_valid, m_ifv);
    check("r_d_vld",   bus.d_valid, m_dv);
    if (m_ifv) begin
      check("r_exp_q_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) exp_if_rdata = exp_q.pop_front();
    end
    if (m_dv && m_d_load) exp_d_rdata = d_next;
    check("r_if_rdata", bus.if_rdata, exp_if_rdata);
    check("r_d_rdata",  bus.d_rdata, exp_d_rdata);
    if (m_busy) begin
      check("r_mem_we",   bus.mem_we, m_we);
      check("r_mem_addr", bus.mem_addr, m_addr);
      if (m_we) begin
        check("r_mem_wd", bus.mem_wdata, m_wdata);
        check("r_mem_be", bus.mem_be, m_be);
      end
    end
    m_ifv    = 1'b0;
    m_dv     = 1'b0;
    m_d_load = 1'b0;
    if (m_busy && bus.mem_ready) begin
      idx = m_addr[5:2];
      if (!m_is_d) begin
        exp_q.push_back(ref_arr[idx]);
        m_ifv = 1'b1;
      end else begin
        m_dv = 1'b1;
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) ref_arr[idx][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_d_load = 1'b1;
          d_next   = ref_arr[idx];
        end
      end
      m_busy = 1'b0;
    end else if (e_d) begin
      m_busy = 1'b1; m_is_d = 1'b1; m_we = bus.d_we;
      m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_be = bus.d_be;
      d_pend = 1'b0;
      if (bus.if_req && m_cnt < MAX_WAIT) m_cnt++;
    end else if (e_i) begin
      m_busy = 1'b1; m_is_d = 1'b0; m_we = 1'b0; m_addr = bus.if_addr;
      f_pend = 1'b0;
      m_cnt  = 0;
    end
  endtask

  int n_d, fetch_at, cnt_at_fetch, nv;

  initial begin
    do_reset();
    mid();
    check_reset_vals("rst");

    // single fetch, memory answers in the first busy cycle
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    mid();
    check("f_if_gnt", bus.if_gnt, 1'b1);
    check("f_d_gnt",  bus.d_gnt, 1'b0);
    check("f_stall",  bus.stall_if, 1'b0);
    check("f_mreq0",  bus.mem_req, 1'b0);
    next_cycle();
    bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
    mid();
    check("f_mreq1",  bus.mem_req, 1'b1);
    check("f_maddr",  bus.mem_addr, 32'h0);
    check("f_mwe",    bus.mem_we, 1'b0);
    check("f_vld1",   bus.if_valid, 1'b0);
    next_cycle();
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    mid();
    check("f_vld2",   bus.if_valid, 1'b1);
    check("f_rdata",  bus.if_rdata, 32'h00500093);
    check("f_mreq2",  bus.mem_req, 1'b0);
    next_cycle();
    mid();
    check("f_vld3",   bus.if_valid, 1'b0);

    // both request: data first, fetch stalled until d_valid
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    mid();
    check("b_d_gnt",   bus.d_gnt, 1'b1);
    check("b_if_gnt0", bus.if_gnt, 1'b0);
    check("b_stall0",  bus.stall_if, 1'b1);
    next_cycle();
    bus.d_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11112222;
    mid();
    check("b_maddr",   bus.mem_addr, 32'h100);
    check("b_stall1",  bus.stall_if, 1'b1);
    check("b_if_gnt1", bus.if_gnt, 1'b0);
    next_cycle();
    bus.mem_ready = 1'b0;
    mid();
    check("b_d_vld",   bus.d_valid, 1'b1);
    check("b_d_rdata", bus.d_rdata, 32'h11112222);
    check("b_if_gnt2", bus.if_gnt, 1'b1);
    check("b_stall2",  bus.stall_if, 1'b0);
    next_cycle();
    bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h22223333;
    mid();
    check("b_maddr2",  bus.mem_addr, 32'h4);
    next_cycle();
    bus.mem_ready = 1'b0;
    mid();
    check("b_if_vld",  bus.if_valid, 1'b1);
    check("b_if_rd",   bus.if_rdata, 32'h22223333);
    check("b_starve",  starve_cnt, 0);

    // fetch starvation bound
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h180;
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    n_d = 0; fetch_at = -1; cnt_at_fetch = -1;
    for (int c = 0; c < 20 && fetch_at < 0; c++) begin
      mid();
      if (bus.d_gnt) n_d++;
      if (bus.if_gnt) begin
        fetch_at     = c;
        cnt_at_fetch = int'(starve_cnt);
      end
      next_cycle();
    end
    check("s_fetch_won", fetch_at >= 0, 1'b1);
    check("s_n_data",    n_d, 4);
    check("s_cnt_sat",   cnt_at_fetch, MAX_WAIT);
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    mid();
    check("s_cnt_clr",   starve_cnt, 0);
    check("s_maddr",     bus.mem_addr, 32'h8);
    next_cycle();
    bus.mem_ready = 1'b0;
    mid();
    check("s_if_vld",    bus.if_valid, 1'b1);
    check("s_if_rd",     bus.if_rdata, 32'h0BADF00D);
    check("s_d_rd",      bus.d_rdata, 32'h0BADF00D);

    // store with three wait cycles
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'hF;
    mid();
    check("w_d_gnt", bus.d_gnt, 1'b1);
    next_cycle();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_be = '0; bus.d_addr = '0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("w_mreq",  bus.mem_req, 1'b1);
      check("w_mwe",   bus.mem_we, 1'b1);
      check("w_maddr", bus.mem_addr, 32'h200);
      check("w_mwd",   bus.mem_wdata, 32'hDEADBEEF);
      check("w_mbe",   bus.mem_be, 4'hF);
      check("w_dvld0", bus.d_valid, 1'b0);
      next_cycle();
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55555555;
    mid();
    check("w_mreq4", bus.mem_req, 1'b1);
    next_cycle();
    bus.mem_ready = 1'b0;
    mid();
    check("w_dvld",  bus.d_valid, 1'b1);
    check("w_d_rd",  bus.d_rdata, 32'h0BADF00D);
    nv = 1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mid();
      if (bus.d_valid) nv++;
    end
    check("w_one_pulse", nv, 1);

    // reset in the middle of a load
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    mid();
    check("r_d_gnt", bus.d_gnt, 1'b1);
    next_cycle();
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    mid();
    check("r_busy",  fsm_state, 2'd2);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("ar");
    @(posedge clk); #1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'hC;
    mid();
    check("ar_first_gnt", bus.if_gnt, 1'b1);
    check("ar_dvld0",     bus.d_valid, 1'b0);
    next_cycle();
    bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    mid();
    check("ar_dvld1",     bus.d_valid, 1'b0);
    check("ar_maddr",     bus.mem_addr, 32'hC);
    next_cycle();
    bus.mem_ready = 1'b0;
    mid();
    check("ar_if_vld",    bus.if_valid, 1'b1);
    check("ar_if_rd",     bus.if_rdata, 32'h12345678);
    check("ar_dvld2",     bus.d_valid, 1'b0);
    check("ar_d_rd",      bus.d_rdata, 0);

    // randomized traffic against the reference model
    next_cycle();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_arr[i] = $urandom;
      mem_arr[i] = ref_arr[i];
    end
    m_busy = 0; m_is_d = 0; m_we = 0; m_ifv = 0; m_dv = 0; m_d_load = 0;
    f_pend = 0; d_pend = 0; m_cnt = 0;
    m_addr = '0; m_wdata = '0; m_be = '0; d_next = '0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) next_cycle();
      drive_random();
      mid();
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
